// File: rtl/syn_gpu_job_dispatch_if.sv
// Local-bus register port of the GPU job dispatcher.
`timescale 1ns/1ps
interface syn_gpu_job_dispatch_if;
    logic [7:0]  lb_addr;
    logic        lb_wr_en;
    logic [31:0] lb_wr_data;
    logic        lb_wr_valid;
    logic        lb_rd_en;
    logic [31:0] lb_rd_data;
    logic        lb_rd_valid;

    modport master (
        output lb_addr, lb_wr_en, lb_wr_data, lb_rd_en,
        input  lb_wr_valid, lb_rd_data, lb_rd_valid
    );

    modport slave (
        input  lb_addr, lb_wr_en, lb_wr_data, lb_rd_en,
        output lb_wr_valid, lb_rd_data, lb_rd_valid
    );
endinterface

// File: rtl/syn_gpu_job_dispatch.sv
// GPU job front-end: LB descriptor registers, job queue and engine dispatcher FSM.
// Optional interrupt block enabled by defining SYN_GPU_JOB_DISPATCH_IRQ_EN.
`timescale 1ns/1ps
module syn_gpu_job_dispatch #(
    parameter int NUM_WORDS   = 10,
    parameter int NUM_ENG     = 4,
    parameter int ACT_W       = 3,
    parameter int JOB_Q_DEPTH = 4
) (
    input  logic                      clk_ir,
    input  logic                      rst_sync,
    syn_gpu_job_dispatch_if.slave     lb,
    output logic [NUM_ENG-1:0]        eng_job_start,
    output logic [16*NUM_WORDS-1:0]   eng_job_data,
    input  logic [NUM_ENG-1:0]        eng_done,
    output logic                      irq
);
    localparam int PTR_W  = $clog2(JOB_Q_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int DESC_W = 16 * NUM_WORDS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic              enable, commit_pend, ovf_sticky, bad_sticky;
    logic [15:0]       job_word [NUM_WORDS];
    logic [DESC_W-1:0] desc;
    logic [DESC_W-1:0] q_mem [JOB_Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [1:0]        state;
    logic [DESC_W-1:0] act_data;
    logic [2:0]        act_eng;
    logic [15:0]       done_cnt;
    logic [31:0]       rd_mux, rd_data_p1, status;
    logic              rd_vld_p1, wr_vld_p1;

    logic              wr_ctrl, wr_stat, wr_cnt, wr_word0, jw_hit, flush_now;
    logic [3:0]        jw_idx;
    logic              q_full, q_empty, pop, push_ok, push_drop, bad_evt, done_hit, act_ok;
    logic [ACT_W-1:0]  head_act;
    logic [NUM_ENG-1:0] eng_sel;
    logic              unused_hi;

    assign jw_idx    = lb.lb_addr[3:0];
    assign jw_hit    = (lb.lb_addr[7:4] == 4'h1) && (32'(jw_idx) < NUM_WORDS);
    assign wr_ctrl   = lb.lb_wr_en && (lb.lb_addr == 8'h00);
    assign wr_stat   = lb.lb_wr_en && (lb.lb_addr == 8'h01);
    assign wr_cnt    = lb.lb_wr_en && (lb.lb_addr == 8'h02);
    assign wr_word0  = lb.lb_wr_en && (lb.lb_addr == 8'h10);
    assign flush_now = wr_ctrl && lb.lb_wr_data[1];
    assign unused_hi = ^lb.lb_wr_data[31:16];

    assign q_full    = (level == LVL_W'(JOB_Q_DEPTH));
    assign q_empty   = (level == '0);
    assign head_act  = q_mem[rd_ptr][ACT_W-1:0];
    assign act_ok    = 32'(head_act) < NUM_ENG;
    // A flush blocks both the pending push and any pop on the same edge.
    assign pop       = (state == ST_IDLE) && enable && !q_empty && !flush_now;
    assign push_ok   = commit_pend && !q_full && !flush_now;
    assign push_drop = commit_pend && q_full && !flush_now;
    assign bad_evt   = pop && !act_ok;

    always_comb begin
        desc = '0;
        for (int i = 0; i < NUM_WORDS; i++) desc[16*i +: 16] = job_word[i];
        eng_sel = '0;
        for (int i = 0; i < NUM_ENG; i++) eng_sel[i] = (act_eng == 3'(i));
    end

    assign done_hit      = (state == ST_WAIT) && |(eng_done & eng_sel);
    assign eng_job_start = (state == ST_ISSUE) ? eng_sel : '0;
    assign eng_job_data  = act_data;

    assign status = {13'd0, act_eng, 3'd0, 5'(level), 3'd0,
                     bad_sticky, ovf_sticky, q_full, q_empty, state != ST_IDLE};

    // ---- descriptor registers and control/status ----
    always_ff @(posedge clk_ir or posedge rst_sync) begin
        if (rst_sync) begin
            for (int i = 0; i < NUM_WORDS; i++) job_word[i] <= '0;
            enable      <= 1'b0;
            commit_pend <= 1'b0;
            ovf_sticky  <= 1'b0;
            bad_sticky  <= 1'b0;
            done_cnt    <= '0;
        end else begin
            if (lb.lb_wr_en && jw_hit) job_word[jw_idx] <= lb.lb_wr_data[15:0];
            if (wr_ctrl) enable <= lb.lb_wr_data[0];
            commit_pend <= wr_word0;
            if (push_drop)                          ovf_sticky <= 1'b1;
            else if (wr_stat && lb.lb_wr_data[3])   ovf_sticky <= 1'b0;
            if (bad_evt)                            bad_sticky <= 1'b1;
            else if (wr_stat && lb.lb_wr_data[4])   bad_sticky <= 1'b0;
            if (wr_cnt)        done_cnt <= '0;
            else if (done_hit) done_cnt <= done_cnt + 16'd1;
        end
    end

    // ---- job queue ----
    always_ff @(posedge clk_ir or posedge rst_sync) begin
        if (rst_sync) begin
            for (int i = 0; i < JOB_Q_DEPTH; i++) q_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                q_mem[wr_ptr] <= desc;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    // ---- dispatcher FSM ----
    always_ff @(posedge clk_ir or posedge rst_sync) begin
        if (rst_sync) begin
            state    <= ST_IDLE;
            act_data <= '0;
            act_eng  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop && act_ok) begin
                        act_data <= q_mem[rd_ptr];
                        act_eng  <= 3'(head_act);
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT:  if (done_hit) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef SYN_GPU_JOB_DISPATCH_IRQ_EN
    logic [2:0] irq_mask, irq_stat, irq_set, irq_clr;
    logic       irq_q;

    assign irq_set = {bad_evt, push_drop, done_hit};
    assign irq_clr = (lb.lb_wr_en && lb.lb_addr == 8'h04) ? lb.lb_wr_data[2:0] : 3'b000;
    assign irq     = irq_q;

    always_ff @(posedge clk_ir or posedge rst_sync) begin
        if (rst_sync) begin
            irq_mask <= '0;
            irq_stat <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (lb.lb_wr_en && lb.lb_addr == 8'h03) irq_mask <= lb.lb_wr_data[2:0];
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            irq_q    <= |(irq_stat & irq_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'hdeadbabe;
        case (lb.lb_addr)
            8'h00: rd_mux = {31'd0, enable};
            8'h01: rd_mux = status;
            8'h02: rd_mux = {16'd0, done_cnt};
`ifdef SYN_GPU_JOB_DISPATCH_IRQ_EN
            8'h03: rd_mux = {29'd0, irq_mask};
            8'h04: rd_mux = {29'd0, irq_stat};
`endif
            default: if (jw_hit) rd_mux = {16'd0, job_word[jw_idx]};
        endcase
    end

    // ---- LB response stage ----
    always_ff @(posedge clk_ir or posedge rst_sync) begin
        if (rst_sync) begin
            wr_vld_p1  <= 1'b0;
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= lb.lb_wr_en;
            rd_vld_p1 <= lb.lb_rd_en;
            if (lb.lb_rd_en) rd_data_p1 <= rd_mux;
        end
    end

    assign lb.lb_wr_valid = wr_vld_p1;
    assign lb.lb_rd_valid = rd_vld_p1;
    assign lb.lb_rd_data  = rd_data_p1;
endmodule

// File: tb/tb_syn_gpu_job_dispatch.sv
// Scoreboard bench for syn_gpu_job_dispatch: stimulus pushes expected LB reads and engine starts.
`timescale 1ns/1ps
module tb_syn_gpu_job_dispatch;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   eng_job_start;
    logic [159:0] eng_job_data;
    logic [3:0]   eng_done = 4'b0;
    logic         irq;
    logic         wr_en_d;

    syn_gpu_job_dispatch_if lb_bus();

    syn_gpu_job_dispatch dut (
        .clk_ir       (clk),
        .rst_sync     (rst),
        .lb           (lb_bus),
        .eng_job_start(eng_job_start),
        .eng_job_data (eng_job_data),
        .eng_done     (eng_done),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   st;
        logic [159:0] data;
    } start_t;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    start_t      st_q[$];
    logic [15:0] mw [10];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] cur_desc();
        logic [159:0] d;
        for (int i = 0; i < 10; i++) d[16*i +: 16] = mw[i];
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lb_write(input logic [7:0] a, input logic [31:0] d);
        int idx;
        lb_bus.lb_addr    = a;
        lb_bus.lb_wr_data = d;
        lb_bus.lb_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        lb_bus.lb_wr_en   = 1'b0;
        idx = int'(a) - 16;
        if (idx >= 0 && idx < 10) mw[idx] = d[15:0];
    endtask

    task automatic lb_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        lb_bus.lb_addr  = a;
        lb_bus.lb_rd_en = 1'b1;
        @(posedge clk);
        #1;
        lb_bus.lb_rd_en = 1'b0;
    endtask

    task automatic commit(input logic [2:0] act, input logic [15:0] w1, input bit exp_start);
        start_t s;
        lb_write(8'h11, {16'h0, w1});
        lb_write(8'h10, {29'h0, act});
        if (exp_start) begin
            s.st   = 4'(1) << act;
            s.data = cur_desc();
            st_q.push_back(s);
        end
    endtask

    task automatic pulse_done(input logic [3:0] m);
        eng_done = m;
        @(posedge clk);
        #1;
        eng_done = 4'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) wr_en_d <= 1'b0;
        else     wr_en_d <= lb_bus.lb_wr_en;
    end

    // monitor: compares whatever the DUT presents against the scoreboard queues
    always @(negedge clk) begin
        if (lb_bus.lb_rd_valid) begin
            if (rd_q.size() == 0) chk("unexpected_rd", 1, 0);
            else chk(rd_name_q.pop_front(), lb_bus.lb_rd_data, rd_q.pop_front());
        end
        if (|eng_job_start) begin
            if (st_q.size() == 0) chk("unexpected_start", eng_job_start, 0);
            else begin
                start_t s;
                s = st_q.pop_front();
                chk("start_onehot", eng_job_start, s.st);
                chk("start_data", eng_job_data, s.data);
            end
        end
        if (lb_bus.lb_wr_valid || wr_en_d) chk("wr_ack", lb_bus.lb_wr_valid, wr_en_d);
    end

    initial begin
        for (int i = 0; i < 10; i++) mw[i] = 16'h0;
        lb_bus.lb_addr    = 8'h0;
        lb_bus.lb_wr_en   = 1'b0;
        lb_bus.lb_wr_data = 32'h0;
        lb_bus.lb_rd_en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", eng_job_start, 0);
        chk("rst_data", eng_job_data, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rd_data", lb_bus.lb_rd_data, 0);
        chk("rst_rd_valid", lb_bus.lb_rd_valid, 0);
        chk("rst_wr_valid", lb_bus.lb_wr_valid, 0);
        rst = 1'b0;
        idle(1);
        lb_read(8'h01, 32'h0000_0002, "status_reset");
        lb_read(8'h02, 32'h0, "cnt_reset");

        // basic dispatch
        lb_write(8'h00, 32'h1);
        for (int i = 1; i < 10; i++) lb_write(8'(16 + i), 32'hABCD_1100 + 32'(i));
        commit(3'd2, 16'h1101, 1'b1);
        idle(4);
        pulse_done(4'b0100);
        idle(2);
        lb_read(8'h02, 32'h1, "cnt_basic");
        lb_read(8'h01, 32'h0002_0002, "status_basic");
        lb_read(8'h13, 32'h0000_1103, "jw3_zext");
        lb_read(8'h05, 32'hdeadbabe, "unmapped_05");
        lb_read(8'h1A, 32'hdeadbabe, "unmapped_1a");
        lb_read(8'h00, 32'h1, "ctrl_rd");

        // backlog with overflow
        lb_write(8'h00, 32'h0);
        lb_write(8'h02, 32'h0);
        for (int k = 0; k < 5; k++) commit(3'(k % 4), 16'h2000 + 16'(k), k < 4);
        idle(2);
        lb_read(8'h01, 32'h0002_040C, "status_full_ovf");
        lb_read(8'h02, 32'h0, "cnt_cleared");
        lb_write(8'h00, 32'h1);
        for (int k = 0; k < 4; k++) begin
            idle(3);
            pulse_done(4'(1) << k);
            idle(1);
        end
        idle(2);
        lb_read(8'h02, 32'h4, "cnt_backlog");
        lb_write(8'h01, 32'h8);
        lb_read(8'h01, 32'h0003_0002, "status_ovf_clr");

        // bad action
        commit(3'd6, 16'h4444, 1'b0);
        idle(4);
        lb_read(8'h01, 32'h0003_0012, "status_bad");
        lb_read(8'h02, 32'h4, "cnt_bad");
        lb_write(8'h01, 32'h10);
        lb_read(8'h01, 32'h0003_0002, "status_bad_clr");

        // flush while a job is in WAIT
        lb_write(8'h00, 32'h0);
        commit(3'd1, 16'h3001, 1'b1);
        commit(3'd2, 16'h3002, 1'b0);
        commit(3'd3, 16'h3003, 1'b0);
        lb_write(8'h00, 32'h1);
        idle(3);
        lb_write(8'h00, 32'h3);
        lb_read(8'h01, 32'h0001_0003, "status_flushed");
        lb_read(8'h00, 32'h1, "ctrl_flush_selfclr");
        pulse_done(4'b0010);
        idle(6);
        lb_read(8'h01, 32'h0001_0002, "status_after_flush");
        lb_read(8'h02, 32'h5, "cnt_flush");

        // wrong-engine done, then reset mid-WAIT
        commit(3'd1, 16'h5001, 1'b1);
        idle(3);
        pulse_done(4'b0001);
        idle(2);
        lb_read(8'h01, 32'h0001_0003, "status_wrong_done");
        idle(1);
        rst = 1'b1;
        #2;
        chk("midrst_start", eng_job_start, 0);
        chk("midrst_data", eng_job_data, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_rd_data", lb_bus.lb_rd_data, 0);
        chk("midrst_rd_valid", lb_bus.lb_rd_valid, 0);
        chk("midrst_wr_valid", lb_bus.lb_wr_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) mw[i] = 16'h0;
        idle(1);
        lb_read(8'h01, 32'h0000_0002, "status_after_rst");
        lb_read(8'h02, 32'h0, "cnt_after_rst");
        lb_read(8'h00, 32'h0, "ctrl_after_rst");
        lb_read(8'h11, 32'h0, "jw1_after_rst");

`ifdef SYN_GPU_JOB_DISPATCH_IRQ_EN
        lb_write(8'h00, 32'h1);
        lb_write(8'h03, 32'h1);
        lb_read(8'h03, 32'h1, "irq_mask_rd");
        commit(3'd3, 16'h6003, 1'b1);
        idle(3);
        pulse_done(4'b1000);
        chk("irq_not_yet", irq, 0);
        idle(1);
        chk("irq_set", irq, 1);
        lb_write(8'h04, 32'h1);
        chk("irq_held", irq, 1);
        idle(1);
        chk("irq_cleared", irq, 0);
        lb_read(8'h04, 32'h0, "irq_stat_rd");
`else
        lb_read(8'h03, 32'hdeadbabe, "irq_mask_unmapped");
        lb_read(8'h04, 32'hdeadbabe, "irq_stat_unmapped");
        lb_write(8'h00, 32'h1);
        commit(3'd3, 16'h6003, 1'b1);
        idle(3);
        pulse_done(4'b1000);
        idle(2);
        chk("irq_tied_low", irq, 0);
`endif
        lb_read(8'h02, 32'h1, "cnt_final");

        idle(5);
        chk("rd_q_left", 160'(rd_q.size()), 0);
        chk("start_q_left", 160'(st_q.size()), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/syn_gpu_job_dispatch.md
Name: syn_gpu_job_dispatch

Overview:
- Next-generation GPU job front-end. Local-bus (LB) registers hold a job descriptor of NUM_WORDS 16-bit words.
- Committing a job pushes a snapshot of the descriptor into a JOB_Q_DEPTH-deep queue.
- A dispatcher FSM pops queued jobs and issues each one to one of NUM_ENG engines, chosen by the job's action field, then waits for that engine's done pulse.
- Sits between the LB decoder and the GPU engines (euclid, picasso, host-access, mulberry, ...). It replaces single-job, fixed-engine register control.

Parameters:
- NUM_WORDS, 10, descriptor words (word0 = action, words 1..NUM_WORDS-1 = engine data); range 2..16.
- NUM_ENG, 4, number of engines; range 1..8.
- ACT_W, 3, width of action field in word0[ACT_W-1:0]; 2^ACT_W >= NUM_ENG.
- JOB_Q_DEPTH, 4, queue depth; power of 2, 2..16.

Ports:
- clk_ir  in  1  clock.
- rst_sync  in  1  asynchronous active-high reset.
- lb_addr  in  8  LB word address.
- lb_wr_en  in  1  LB write strobe.
- lb_wr_data  in  32  LB write data.
- lb_wr_valid  out  1  write acknowledge.
- lb_rd_en  in  1  LB read strobe.
- lb_rd_data  out  32  read data.
- lb_rd_valid  out  1  read data valid.
- eng_job_start  out  NUM_ENG  one-hot, one-cycle start pulse.
- eng_job_data  out  16*NUM_WORDS  descriptor of the active job; word i at [16i+15:16i].
- eng_done  in  NUM_ENG  per-engine one-cycle completion pulse.
- irq  out  1  interrupt (optional feature only).

Behaviour:
- Reset values: all outputs 0 except lb_rd_data = 0. Queue empty, FSM IDLE, all registers 0.
- LB timing:
  - lb_wr_valid = lb_wr_en delayed 1 cycle.
  - lb_rd_valid = lb_rd_en delayed 1 cycle; lb_rd_data updates in the same cycle lb_rd_valid asserts.
  - Unmapped read returns 32'hdeadbabe. Unmapped write is ignored.
- Register map:
  - 0x00 CONTROL: bit0 enable (RW); bit1 flush (write 1, self-clearing, reads 0).
  - 0x01 STATUS:
    - bit0 FSM not IDLE.
    - bit1 queue empty.
    - bit2 queue full.
    - bit3 overflow sticky; cleared by writing 1 to STATUS bit3.
    - bit4 bad-action sticky; cleared by writing 1 to STATUS bit4.
    - [12:8] queue level.
    - [18:16] active engine index.
  - 0x02 DONE_CNT: 16-bit count of completed jobs; wraps 0xFFFF -> 0; cleared by any write.
  - 0x10+i JOB_WORD_i, i < NUM_WORDS: RW, lower 16 bits stored; reads zero-extended.
- Commit: a write to JOB_WORD_0 stores the word, and in the next cycle the full descriptor (including the new word0) is pushed into the queue.
  - If the queue is full at push time, the push is dropped and overflow is set, even if a pop occurs in the same cycle.
  - Otherwise the level increments. Simultaneous push and pop leaves the level unchanged.
- Flush: the queue empties in the cycle after the write. The in-flight job is not aborted. A commit in the same cycle as flush is dropped (no overflow flag).
- Dispatcher FSM:
  - IDLE: if enable=1 and queue non-empty, pop the head into the active register.
    - If action < NUM_ENG, go to ISSUE.
    - Otherwise set bad-action, discard the job (DONE_CNT not incremented), and stay in IDLE.
  - ISSUE: eng_job_start[action]=1 for exactly 1 cycle; eng_job_data is valid from this cycle until the return to IDLE. Go to WAIT.
  - WAIT: on eng_done[action], increment DONE_CNT and return to IDLE. done pulses on other engines are ignored. A done pulse during ISSUE is also ignored.
  - Clearing enable stops new pops only; an active job still completes.
- Minimum job turnaround: IDLE -> ISSUE -> WAIT -> IDLE, 3 cycles. Back-to-back jobs therefore issue at most every 3 cycles.
- Reset mid-operation: everything is cleared immediately, with no start or done side effects.

Optional Feature:
- Macro: SYN_GPU_JOB_DISPATCH_IRQ_EN.
- With the macro defined:
  - Register 0x03 IRQ_MASK: bits[2:0] RW, enabling done, overflow and bad-action.
  - Register 0x04 IRQ_STAT: bits[2:0] sticky W1C; bit0 is set on each job completion.
  - irq = |(IRQ_STAT & IRQ_MASK), registered, so it asserts 1 cycle after the sticky bit sets.
- Without the macro: irq is tied 0, and 0x03/0x04 read 32'hdeadbabe and ignore writes.

Test Plan:
- Basic dispatch, enable=1: write words 1..9, then word0=2 -> commit.
  - eng_job_start=4'b0100 for 1 cycle; eng_job_data holds the written words.
  - After eng_done[2], DONE_CNT=1 and STATUS bit0=0.
- Backlog with JOB_Q_DEPTH=4 and enable=0:
  - Commit 5 jobs -> STATUS level=4, full=1, overflow=1.
  - Set enable=1 and return done for each -> exactly 4 starts, in commit order, and DONE_CNT=4.
- Bad action, NUM_ENG=4: commit word0=6 -> no start pulse; bad-action=1; DONE_CNT unchanged; queue empty.
- Flush during active job: 3 queued jobs, the first in WAIT; write CONTROL=0x3 -> level=0. The active job still finishes on eng_done; no further starts follow.
- Wrong-engine done and reset: while waiting on engine 1, pulse eng_done[0] -> stays busy. Assert rst_sync mid-WAIT -> all outputs 0, STATUS reads 0x00000002.
- IRQ (macro defined): IRQ_MASK=0x1; complete a job -> irq=1 one cycle after completion; write IRQ_STAT=0x1 -> irq=0 next cycle.
